// File: rtl/i2c_txn_sequencer.sv
// Command front-end for the I2C controller: queues transaction requests, launches them
// one at a time on the en/busy handshake and returns one response (data or timeout) per command.
module i2c_txn_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  cfg_mode,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [6:0]                  cmd_addr,
    input  logic [7:0]                  cmd_reg,
    input  logic                        cmd_rw,
    input  logic [15:0]                 cmd_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [15:0]                 rsp_data,
    output logic                        rsp_rw,
    output logic                        rsp_timeout,
    output logic                        ctl_en,
    output logic [1:0]                  ctl_mode,
    output logic [6:0]                  ctl_peripheral_address,
    output logic [7:0]                  ctl_target_register,
    output logic                        ctl_rw,
    output logic [15:0]                 ctl_din,
    input  logic                        ctl_busy,
    input  logic [15:0]                 ctl_dout,
    output logic                        idle,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        ACTIVE  = 3'd2,
        CAPTURE = 3'd3,
        ABORT   = 3'd4,
        GAP     = 3'd5
    } state_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [7:0]  rgst;
        logic        rw;
        logic [15:0] data;
    } cmd_t;

    cmd_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             busy_meta_q, busy_s_q;
    logic             push, pop;
    cmd_t             head;

    logic        ctl_en_q, ctl_en_d;
    logic [1:0]  ctl_mode_q, ctl_mode_d;
    logic [6:0]  ctl_addr_q, ctl_addr_d;
    logic [7:0]  ctl_reg_q, ctl_reg_d;
    logic        ctl_rw_q, ctl_rw_d;
    logic [15:0] ctl_din_q, ctl_din_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_rw_q, rsp_rw_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    assign cmd_ready = (level_q != DEPTH_L);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        pop           = 1'b0;
        state_d       = state_q;
        wd_d          = wd_q;
        gap_d         = '0;
        ctl_en_d      = ctl_en_q;
        ctl_mode_d    = ctl_mode_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_reg_d     = ctl_reg_q;
        ctl_rw_d      = ctl_rw_q;
        ctl_din_d     = ctl_din_q;
        rsp_valid_d   = rsp_valid_q && !rsp_ready;
        rsp_data_d    = rsp_data_q;
        rsp_rw_d      = rsp_rw_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                // A pending response blocks launches so responses never overwrite each other.
                if (level_q != '0 && !rsp_valid_q) begin
                    pop        = 1'b1;
                    ctl_addr_d = head.addr;
                    ctl_reg_d  = head.rgst;
                    ctl_rw_d   = head.rw;
                    ctl_din_d  = head.data;
                    ctl_mode_d = cfg_mode;
                    ctl_en_d   = 1'b1;
                    wd_d       = '0;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                if (busy_s_q) begin
                    wd_d    = '0;
                    state_d = ACTIVE;
                end else if (wd_q == WD_LAST) begin
                    ctl_en_d = 1'b0;
                    state_d  = ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ACTIVE: begin
                if (!busy_s_q) begin
                    ctl_en_d = 1'b0;
                    state_d  = CAPTURE;
                end else if (wd_q == WD_LAST) begin
                    ctl_en_d = 1'b0;
                    state_d  = ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            CAPTURE: begin
                rsp_data_d    = ctl_dout;
                rsp_rw_d      = ctl_rw_q;
                rsp_timeout_d = 1'b0;
                rsp_valid_d   = 1'b1;
                state_d       = GAP;
            end
            ABORT: begin
                ctl_en_d      = 1'b0;
                rsp_data_d    = '0;
                rsp_rw_d      = ctl_rw_q;
                rsp_timeout_d = 1'b1;
                rsp_valid_d   = 1'b1;
                state_d       = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            wd_q          <= '0;
            gap_q         <= '0;
            busy_meta_q   <= 1'b0;
            busy_s_q      <= 1'b0;
            ctl_en_q      <= 1'b0;
            ctl_mode_q    <= '0;
            ctl_addr_q    <= '0;
            ctl_reg_q     <= '0;
            ctl_rw_q      <= 1'b0;
            ctl_din_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_rw_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
            busy_meta_q   <= ctl_busy;
            busy_s_q      <= busy_meta_q;
            ctl_en_q      <= ctl_en_d;
            ctl_mode_q    <= ctl_mode_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_reg_q     <= ctl_reg_d;
            ctl_rw_q      <= ctl_rw_d;
            ctl_din_q     <= ctl_din_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_rw_q      <= rsp_rw_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: cmd_addr, rgst: cmd_reg, rw: cmd_rw, data: cmd_data};
        end
    end

    assign ctl_en                 = ctl_en_q;
    assign ctl_mode               = ctl_mode_q;
    assign ctl_peripheral_address = ctl_addr_q;
    assign ctl_target_register    = ctl_reg_q;
    assign ctl_rw                 = ctl_rw_q;
    assign ctl_din                = ctl_din_q;
    assign rsp_valid              = rsp_valid_q;
    assign rsp_data               = rsp_data_q;
    assign rsp_rw                 = rsp_rw_q;
    assign rsp_timeout            = rsp_timeout_q;
    assign fifo_level             = level_q;
    assign idle                   = (state_q == IDLE) && (level_q == '0);

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Scoreboard bench for i2c_txn_sequencer with a behavioural controller model on en/busy.
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;

    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int GAP_CYCLES     = 4;
    localparam int M_LEN          = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic        cmd_valid, cmd_ready;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_reg;
    logic        cmd_rw;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_rw, rsp_timeout;
    logic        ctl_en;
    logic [1:0]  ctl_mode;
    logic [6:0]  ctl_peripheral_address;
    logic [7:0]  ctl_target_register;
    logic        ctl_rw;
    logic [15:0] ctl_din;
    logic        ctl_busy;
    logic [15:0] ctl_dout;
    logic        idle;
    logic [2:0]  fifo_level;

    i2c_txn_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_reg(cmd_reg), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rw(rsp_rw), .rsp_timeout(rsp_timeout),
        .ctl_en(ctl_en), .ctl_mode(ctl_mode),
        .ctl_peripheral_address(ctl_peripheral_address),
        .ctl_target_register(ctl_target_register), .ctl_rw(ctl_rw),
        .ctl_din(ctl_din), .ctl_busy(ctl_busy), .ctl_dout(ctl_dout),
        .idle(idle), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] data; logic rw; logic to; } rsp_t;
    typedef struct packed { logic [6:0] addr; logic [7:0] rgst; logic rw; logic [15:0] data; } cmd_t;

    rsp_t exp_rsp[$];
    cmd_t exp_cmd[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rsp_cnt = 0;
    int   launch_cnt = 0;
    int   stable_err = 0;
    int   hi_run = 0, lo_run = 0, last_hi_len = 0, min_gap = 1000;
    logic prev_en = 1'b0;
    cmd_t en_fields;

    // Controller model state
    logic [15:0] m_xor = 16'h0000;
    logic        m_stall = 1'b0;
    logic        m_never = 1'b0;
    int          m_st = 0, m_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_st = 0;
            ctl_busy = 1'b0;
        end else begin
            case (m_st)
                0: if (ctl_en && !m_never) begin
                    n_cmp++;
                    if (exp_cmd.size() == 0) begin
                        n_err++;
                        $display("FAIL ctl_launch: unexpected launch din=%h", ctl_din);
                    end else begin
                        cmd_t c;
                        c = exp_cmd.pop_front();
                        if ({ctl_peripheral_address, ctl_target_register, ctl_rw, ctl_din} !== c
                            || ctl_mode !== 2'b10) begin
                            n_err++;
                            $display("FAIL ctl_fields: got %h/%h/%b/%h mode %b, want %h/%h/%b/%h mode 10",
                                     ctl_peripheral_address, ctl_target_register, ctl_rw, ctl_din,
                                     ctl_mode, c.addr, c.rgst, c.rw, c.data);
                        end
                    end
                    m_cnt = 0;
                    m_st = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 2) begin
                        ctl_busy = 1'b1;
                        m_cnt = 0;
                        m_st = 2;
                    end
                end
                2: begin
                    m_cnt++;
                    if (m_cnt >= M_LEN && !m_stall) begin
                        ctl_dout = ctl_din ^ m_xor;
                        ctl_busy = 1'b0;
                        m_st = 3;
                    end
                end
                default: if (!ctl_en) m_st = 0;
            endcase
        end
    end

    // Response scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            n_cmp++;
            if (exp_rsp.size() == 0) begin
                n_err++;
                $display("FAIL rsp_extra: data=%h rw=%b to=%b with nothing expected",
                         rsp_data, rsp_rw, rsp_timeout);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                if ({rsp_data, rsp_rw, rsp_timeout} !== e) begin
                    n_err++;
                    $display("FAIL rsp_content: got %h/%b/%b, want %h/%b/%b",
                             rsp_data, rsp_rw, rsp_timeout, e.data, e.rw, e.to);
                end
            end
        end
    end

    // ctl_en run lengths and field stability
    always @(negedge clk) begin
        if (ctl_en && !prev_en) begin
            launch_cnt++;
            if (launch_cnt > 1 && lo_run < min_gap) min_gap = lo_run;
            en_fields = {ctl_peripheral_address, ctl_target_register, ctl_rw, ctl_din};
            hi_run = 1;
        end else if (ctl_en) begin
            hi_run++;
            if ({ctl_peripheral_address, ctl_target_register, ctl_rw, ctl_din} !== en_fields)
                stable_err++;
        end else if (prev_en) begin
            last_hi_len = hi_run;
            lo_run = 1;
        end else begin
            lo_run++;
        end
        prev_en = ctl_en;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic [7:0] r, input logic rw,
                            input logic [15:0] d, input logic to);
        int k;
        cmd_valid = 1'b1; cmd_addr = a; cmd_reg = r; cmd_rw = rw; cmd_data = d;
        k = 0;
        while (!cmd_ready && k < 200) begin
            cyc(1);
            k++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, k);
        end else begin
            exp_rsp.push_back(to ? {16'h0000, rw, 1'b1} : {d ^ m_xor, rw, 1'b0});
            if (!to) exp_cmd.push_back({a, r, rw, d});
        end
        cyc(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int bound);
        int k;
        k = 0;
        while (rsp_cnt < target && k < bound) begin
            cyc(1);
            k++;
        end
        n_cmp++;
        if (rsp_cnt < target) begin
            n_err++;
            $display("FAIL rsp_wait: responses=%0d, want %0d", rsp_cnt, target);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_addr = 7'h11; cmd_reg = 8'h22; cmd_rw = 1'b1;
        cmd_data = 16'h3333;
        cyc(3);
        n_cmp += 7;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        if (ctl_en !== 1'b0) begin n_err++; $display("FAIL rst_ctl_en: got %b want 0", ctl_en); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle); end
        if (rsp_data !== 16'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        if (ctl_din !== 16'h0) begin n_err++; $display("FAIL rst_ctl_din: got %h want 0", ctl_din); end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        cyc(3);
        n_cmp += 2;
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_no_push: level %0d want 0", fifo_level); end
        if (launch_cnt !== 0) begin n_err++; $display("FAIL rst_no_launch: launches %0d want 0", launch_cnt); end
    endtask

    task automatic test_single_read;
        int base;
        base = rsp_cnt;
        m_xor = 16'hBEEF;
        send_cmd(7'h48, 8'h01, 1'b0, 16'h0000, 1'b0);
        wait_rsp(base + 1, 300);
        cyc(20);
        n_cmp += 3;
        if (rsp_cnt !== base + 1) begin n_err++; $display("FAIL read_count: got %0d want %0d", rsp_cnt, base + 1); end
        if (last_hi_len <= M_LEN) begin n_err++; $display("FAIL read_en_len: got %0d want >%0d", last_hi_len, M_LEN); end
        if (ctl_en !== 1'b0) begin n_err++; $display("FAIL read_en_low: got %b want 0", ctl_en); end
    endtask

    task automatic test_queue_order;
        int base;
        base = rsp_cnt;
        m_xor = 16'h0F0F;
        m_stall = 1'b1;
        send_cmd(7'h50, 8'h10, 1'b1, 16'h1111, 1'b0);
        cyc(3);
        n_cmp++;
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL q_first_pop: level %0d want 0", fifo_level); end
        send_cmd(7'h50, 8'h11, 1'b1, 16'h2222, 1'b0);
        send_cmd(7'h50, 8'h12, 1'b1, 16'h3333, 1'b0);
        send_cmd(7'h50, 8'h13, 1'b1, 16'h4444, 1'b0);
        send_cmd(7'h50, 8'h14, 1'b1, 16'h5555, 1'b0);
        n_cmp += 2;
        if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL q_full_ready: got %b want 0", cmd_ready); end
        if (fifo_level !== 3'd4) begin n_err++; $display("FAIL q_full_level: got %0d want 4", fifo_level); end
        m_stall = 1'b0;
        wait_rsp(base + 5, 600);
        cyc(2);
        n_cmp += 2;
        if (exp_cmd.size() != 0) begin n_err++; $display("FAIL q_all_launched: %0d left want 0", exp_cmd.size()); end
        if (min_gap < GAP_CYCLES) begin n_err++; $display("FAIL q_gap: min low %0d want >=%0d", min_gap, GAP_CYCLES); end
    endtask

    task automatic test_backpressure;
        int base, bl, k;
        logic [15:0] held;
        base = rsp_cnt;
        m_xor = 16'h1234;
        rsp_ready = 1'b0;
        bl = launch_cnt;
        send_cmd(7'h21, 8'h40, 1'b0, 16'hA0A0, 1'b0);
        send_cmd(7'h22, 8'h41, 1'b0, 16'hB0B0, 1'b0);
        k = 0;
        while (!rsp_valid && k < 200) begin cyc(1); k++; end
        held = rsp_data;
        cyc(20);
        n_cmp += 5;
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", rsp_valid); end
        if (rsp_data !== held) begin n_err++; $display("FAIL bp_stable: got %h want %h", rsp_data, held); end
        if (rsp_data !== (16'hA0A0 ^ 16'h1234)) begin n_err++; $display("FAIL bp_data: got %h want %h", rsp_data, 16'hA0A0 ^ 16'h1234); end
        if (ctl_en !== 1'b0 || launch_cnt !== bl + 1) begin
            n_err++; $display("FAIL bp_stall: en=%b launches=%0d want 0/%0d", ctl_en, launch_cnt, bl + 1);
        end
        if (fifo_level !== 3'd1) begin n_err++; $display("FAIL bp_level: got %0d want 1", fifo_level); end
        rsp_ready = 1'b1;
        k = 0;
        while (!ctl_en && k < 3) begin cyc(1); k++; end
        n_cmp++;
        if (ctl_en !== 1'b1) begin n_err++; $display("FAIL bp_relaunch: en=%b after %0d cycles want 1", ctl_en, k); end
        wait_rsp(base + 2, 300);
    endtask

    task automatic test_timeout;
        int base;
        base = rsp_cnt;
        m_xor = 16'h00FF;
        m_never = 1'b1;
        send_cmd(7'h33, 8'h55, 1'b1, 16'h7777, 1'b1);
        send_cmd(7'h34, 8'h56, 1'b1, 16'h8888, 1'b0);
        wait_rsp(base + 1, 200);
        m_never = 1'b0;
        n_cmp++;
        if (last_hi_len !== TIMEOUT_CYCLES) begin
            n_err++; $display("FAIL to_en_len: got %0d want %0d", last_hi_len, TIMEOUT_CYCLES);
        end
        wait_rsp(base + 2, 300);
    endtask

    task automatic test_reset_mid;
        int base, bl, k;
        m_stall = 1'b1;
        m_xor = 16'h0000;
        send_cmd(7'h60, 8'h01, 1'b0, 16'hC001, 1'b0);
        cyc(3);
        send_cmd(7'h60, 8'h02, 1'b0, 16'hC002, 1'b0);
        send_cmd(7'h60, 8'h03, 1'b0, 16'hC003, 1'b0);
        k = 0;
        while (!ctl_busy && k < 50) begin cyc(1); k++; end
        cyc(6);
        base = rsp_cnt;
        bl = launch_cnt;
        n_cmp++;
        if (fifo_level !== 3'd2 || ctl_en !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: level=%0d en=%b want 2/1", fifo_level, ctl_en);
        end
        rst_n = 1'b0;
        cyc(1);
        n_cmp += 3;
        if (ctl_en !== 1'b0) begin n_err++; $display("FAIL mid_en: got %b want 0", ctl_en); end
        if (fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp: got %b want 0", rsp_valid); end
        cyc(1);
        rst_n = 1'b1;
        m_stall = 1'b0;
        exp_rsp.delete();
        exp_cmd.delete();
        cyc(30);
        n_cmp += 3;
        if (rsp_cnt !== base) begin n_err++; $display("FAIL mid_no_rsp: got %0d want %0d", rsp_cnt, base); end
        if (launch_cnt !== bl) begin n_err++; $display("FAIL mid_no_launch: got %0d want %0d", launch_cnt, bl); end
        if (idle !== 1'b1) begin n_err++; $display("FAIL mid_idle: got %b want 1", idle); end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cfg_mode = 2'b10; cmd_valid = 1'b0; cmd_addr = '0; cmd_reg = '0;
        cmd_rw = 1'b0; cmd_data = '0; rsp_ready = 1'b1; ctl_busy = 1'b0; ctl_dout = '0;
        test_reset();
        test_single_read();
        test_queue_order();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        n_cmp += 2;
        if (exp_rsp.size() != 0) begin n_err++; $display("FAIL end_rsp_left: %0d want 0", exp_rsp.size()); end
        if (stable_err != 0) begin n_err++; $display("FAIL ctl_stable: %0d changes while en, want 0", stable_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Command front-end that sits directly upstream of the I2C controller. It buffers transaction requests (address, register, rw, 16-bit data) from a valid/ready producer in a small FIFO and launches them one at a time on the controller's en/busy interface. After each transaction it captures the controller's 16-bit read result and returns it as a valid/ready response. A watchdog turns a stuck transaction into a timeout response.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 1000000, clk cycles allowed per phase (busy rise, busy fall) before abort.
GAP_CYCLES, 4, minimum clk cycles ctl_en is held low between transactions.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
cfg_mode  in  2  I2C speed mode, sampled at launch
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_addr  in  7  7-bit peripheral address
cmd_reg  in  8  target register
cmd_rw  in  1  1=write, 0=read (controller encoding)
cmd_data  in  16  write data, MSB byte sent first
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  16  captured ctl_dout (0 on timeout)
rsp_rw  out  1  rw of the completed command
rsp_timeout  out  1  transaction aborted by watchdog
ctl_en  out  1  to controller en
ctl_mode  out  2  to controller mode
ctl_peripheral_address  out  7  to controller
ctl_target_register  out  8  to controller
ctl_rw  out  1  to controller
ctl_din  out  16  to controller
ctl_busy  in  1  from controller busy (i2c clock domain)
ctl_dout  in  16  from controller dout
idle  out  1  FIFO empty and FSM in IDLE
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (rst_n=0 at posedge clk): FIFO empty, fifo_level=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_rw=0, rsp_timeout=0, ctl_en=0, all ctl_* fields 0, FSM=IDLE, idle=1, watchdog=0, busy synchroniser cleared. Reset mid-transaction drops ctl_en in the next cycle and discards all queued commands. No response is produced for them.
- ctl_busy passes through a 2-flop synchroniser (busy_s) before use. ctl_dout is sampled only in CAPTURE.
- FIFO: push when cmd_valid&&cmd_ready; cmd_ready=(fifo_level<FIFO_DEPTH). A pop happens only on the IDLE->LAUNCH transition. A simultaneous push and pop leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH. Entries are delivered in order.
- FSM:
  - IDLE: if the FIFO is non-empty and rsp_valid=0, pop the head, load the ctl_* fields and ctl_mode<=cfg_mode, set ctl_en=1, clear the watchdog, go to LAUNCH.
  - LAUNCH: ctl_en=1. On busy_s=1, clear the watchdog and go to ACTIVE. If the watchdog reaches TIMEOUT_CYCLES-1, go to ABORT.
  - ACTIVE: ctl_en=1. On busy_s=0, set ctl_en=0 in the same edge and go to CAPTURE. If the watchdog reaches TIMEOUT_CYCLES-1, go to ABORT.
  - CAPTURE (1 cycle): rsp_data<=ctl_dout, rsp_rw<=ctl_rw, rsp_timeout<=0, rsp_valid<=1, go to GAP.
  - ABORT (1 cycle): ctl_en=0, rsp_data<=0, rsp_rw<=ctl_rw, rsp_timeout<=1, rsp_valid<=1, go to GAP.
  - GAP: ctl_en=0 for GAP_CYCLES cycles, then go to IDLE.
- The ctl_* fields are held stable from launch until the next launch. They never change while ctl_en=1.
- Response: rsp_valid stays high with stable data until rsp_valid&&rsp_ready, then clears next cycle. No new launch while rsp_valid=1 (single-entry response, backpressure stalls the queue; the command FIFO keeps accepting).
- Every command, read or write, yields exactly one response.
- Integration constraint: the controller's i2c data-clock period must exceed 4 clk cycles, so ctl_en falls before the controller's next START edge after STOP.
- Watchdog is a counter of width $clog2(TIMEOUT_CYCLES). It counts only in LAUNCH and ACTIVE and saturates until the state changes.
- idle=(FSM==IDLE)&&(fifo_level==0).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with cmd_valid=1 -> cmd_ready=1, fifo_level=0, ctl_en=0, rsp_valid=0. No push is recorded.
- Single read: cmd addr=0x48, reg=0x01, rw=0 with a controller model returning dout=0xBEEF -> ctl_en high until busy_s falls. Exactly one response with rsp_data=0xBEEF, rsp_rw=0, rsp_timeout=0. ctl_en low for at least GAP_CYCLES.
- Queue fill and order: push 5 writes (din 0x1111..0x5555) with FIFO_DEPTH=4 and the controller stalled -> cmd_ready=0 after entry 4 (the 1st already popped). Controller sees din in order 0x1111..0x5555, and 5 responses arrive in order.
- Response backpressure: rsp_ready=0 with 2 queued commands -> after the 1st completes, ctl_en stays 0 and rsp_data is stable. Raising rsp_ready launches the 2nd within 2 cycles after GAP.
- Timeout: TIMEOUT_CYCLES=64, model never raises busy -> at cycle 64 of LAUNCH, ctl_en=0 and the response has rsp_timeout=1, rsp_data=0x0000. The next queued command then launches normally.
- Reset mid-transaction: rst_n=0 while in ACTIVE with 2 commands queued -> ctl_en=0 next cycle, fifo_level=0. No response is issued.
